// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that streams a length-prefixed byte image into
// the instruction memory write port, holding the core off until the load ends.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned MAX_WORDS = 65536
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_write_en,
   output logic [ADDR_W-1:0] imem_write_addr,
   output logic [31:0]       imem_write_data,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [16:0]       words_loaded
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned PART_W = 24;
   localparam int unsigned CNT_W  = 17;
   localparam int unsigned BCNT_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK = 3'd4,
`endif
      ST_DONE  = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [WORD_W-1:0]   len_q, len_d;
   logic [PART_W-1:0]   word_q, word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0]   csum_q, csum_d;
`endif
   logic                rx_ready_q, rx_ready_d;
   logic                wen_q, wen_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic                hold_q, hold_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    wl_q, wl_d;

   logic                accept;
   logic                finish;
   logic                fail;
   logic [WORD_W-1:0]   len_next;
   logic [WORD_W-1:0]   word_next;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      len_d      = len_q;
      word_d     = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      rx_ready_d = 1'b0;
      wen_d      = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      hold_d     = hold_q;
      done_d     = done_q;
      err_d      = err_q;
      wl_d       = wl_q;
      finish     = 1'b0;
      fail       = 1'b0;
      accept     = rx_valid && rx_ready_q;
      len_next   = {rx_data, len_q[WORD_W-1:BYTE_W]};
      word_next  = {rx_data, word_q};

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_LEN;
               byte_cnt_d = '0;
               len_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = '0;
`endif
               hold_d     = 1'b1;
               done_d     = 1'b0;
               err_d      = 1'b0;
               wl_d       = '0;
            end
         end

         ST_LEN: begin
            if (abort) begin
               finish = 1'b1;
               fail   = 1'b1;
            end else if (accept) begin
               len_d      = len_next;
               byte_cnt_d = BCNT_W'(byte_cnt_q + 2'd1);
               if (byte_cnt_q == 2'd3) begin
                  if (len_next == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_d = ST_CHECK;
`else
                     finish  = 1'b1;
`endif
                  end else if (len_next > MAX_WORDS) begin
                     finish = 1'b1;
                     fail   = 1'b1;
                  end else begin
                     state_d = ST_DATA;
                  end
               end
            end
         end

         ST_DATA: begin
            if (abort) begin
               finish = 1'b1;
               fail   = 1'b1;
            end else if (accept) begin
               word_d     = word_next[WORD_W-1:BYTE_W];
               byte_cnt_d = BCNT_W'(byte_cnt_q + 2'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = csum_q ^ rx_data;
`endif
               // The completing byte launches the write for the next cycle
               if (byte_cnt_q == 2'd3) begin
                  state_d = ST_WRITE;
                  wen_d   = 1'b1;
                  waddr_d = ADDR_W'(BASE_ADDR + WORD_W'(wl_q));
                  wdata_d = word_next;
               end
            end
         end

         ST_WRITE: begin
            // The strobe is already on the port; count it even if aborted
            wl_d = CNT_W'(wl_q + 17'd1);
            if (abort) begin
               finish = 1'b1;
               fail   = 1'b1;
            end else if ((WORD_W'(wl_q) + 32'd1) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = ST_CHECK;
`else
               finish  = 1'b1;
`endif
            end else begin
               state_d = ST_DATA;
            end
         end

`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (abort) begin
               finish = 1'b1;
               fail   = 1'b1;
            end else if (accept) begin
               finish = 1'b1;
               fail   = (rx_data != csum_q);
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
            hold_d  = 1'b0;
         end
      endcase

      if (finish) begin
         state_d = ST_DONE;
         done_d  = 1'b1;
         hold_d  = 1'b0;
         if (fail) begin
            err_d = 1'b1;
         end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      rx_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHECK);
`else
      rx_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA);
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_q <= '0;
         len_q      <= '0;
         word_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
         rx_ready_q <= 1'b0;
         wen_q      <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wl_q       <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         len_q      <= len_d;
         word_q     <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
         rx_ready_q <= rx_ready_d;
         wen_q      <= wen_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
         wl_q       <= wl_d;
      end
   end

   assign rx_ready        = rx_ready_q;
   assign imem_write_en   = wen_q;
   assign imem_write_addr = waddr_q;
   assign imem_write_data = wdata_q;
   assign cpu_hold        = hold_q;
   assign load_done       = done_q;
   assign load_error      = err_q;
   assign words_loaded    = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: random images against a byte-stream reference model.
module tb_imem_loader;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned BASE   = 32'h0000_FFFF;
   localparam int unsigned MAXW   = 65536;

   typedef logic [7:0] bq_t[$];

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_valid = 1'b0;
   logic              rx_ready;
   logic              imem_write_en;
   logic [ADDR_W-1:0] imem_write_addr;
   logic [31:0]       imem_write_data;
   logic              cpu_hold;
   logic              load_done;
   logic              load_error;
   logic [16:0]       words_loaded;

   int n_checks = 0;
   int n_errs   = 0;

   logic [ADDR_W-1:0] got_addr[$];
   logic [31:0]       got_data[$];

   always #5 clk = ~clk;

   imem_loader #(
      .ADDR_W   (ADDR_W),
      .BASE_ADDR(BASE),
      .MAX_WORDS(MAXW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .imem_write_en  (imem_write_en),
      .imem_write_addr(imem_write_addr),
      .imem_write_data(imem_write_data),
      .cpu_hold       (cpu_hold),
      .load_done      (load_done),
      .load_error     (load_error),
      .words_loaded   (words_loaded)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Capture every write strobe seen on the memory port
   always @(negedge clk) begin
      if (rst_n && imem_write_en) begin
         got_addr.push_back(imem_write_addr);
         got_data.push_back(imem_write_data);
         check("wr_rx_ready_low", 64'(rx_ready), 64'd0);
         check("wr_cpu_hold", 64'(cpu_hold), 64'd1);
      end
   end

   // Reference: word i of an image is bytes 4i..4i+3, little-endian
   function automatic logic [31:0] word_of(input bq_t d, input int i);
      return {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]};
   endfunction

   function automatic logic [ADDR_W-1:0] addr_of(input int i);
      return ADDR_W'((BASE + 32'(i)) % 65536);
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit gappy);
      bit sent = 1'b0;
      int guard = 0;
      while (!sent) begin
         @(negedge clk);
         if (gappy && ($urandom_range(0, 1) == 1)) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
         end else begin
            rx_valid = 1'b1;
            rx_data  = b;
            sent     = rx_ready;
         end
         guard++;
         if (!sent && guard > 500) begin
            check("rx_accept_timeout", 64'd0, 64'd1);
            sent = 1'b1;
         end
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_cpu_hold", 64'(cpu_hold), 64'd1);
      check("start_done_clr", 64'(load_done), 64'd0);
      check("start_err_clr", 64'(load_error), 64'd0);
      check("start_wl_clr", 64'(words_loaded), 64'd0);
   endtask

   task automatic wait_done(input string tag);
      int cyc = 0;
      while (!load_done && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_done"}, 64'(load_done), 64'd1);
   endtask

   task automatic check_writes(input string tag, input bq_t d, input int exp_w);
      check({tag, "_nwrites"}, 64'(got_addr.size()), 64'(exp_w));
      for (int i = 0; i < exp_w; i++) begin
         if (i < got_addr.size()) begin
            check({tag, "_addr"}, 64'(got_addr[i]), 64'(addr_of(i)));
            check({tag, "_data"}, 64'(got_data[i]), 64'(word_of(d, i)));
         end
      end
   endtask

   task automatic run_load(input string tag, input int unsigned n, input bq_t d,
                           input logic [7:0] tweak, input bit gappy);
      bit over;
      bit exp_err;
      int exp_w;
      logic [7:0] x;
      over = (n > MAXW);
      x    = 8'h00;
      got_addr.delete();
      got_data.delete();
      do_start();
      for (int i = 0; i < 4; i++) send_byte(8'(n >> (8 * i)), gappy);
      if (!over) begin
         foreach (d[i]) begin
            send_byte(d[i], gappy);
            x = x ^ d[i];
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!over) send_byte(x ^ tweak, gappy);
      exp_err = over || (tweak != 8'h00);
`else
      exp_err = over;
`endif
      @(negedge clk);
      rx_valid = 1'b0;
      wait_done(tag);
      exp_w = over ? 0 : int'(n);
      check_writes(tag, d, exp_w);
      check({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_w));
      check({tag, "_error"}, 64'(load_error), 64'(exp_err));
      check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
      check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
      check({tag, "_wen"}, 64'(imem_write_en), 64'd0);
      check({tag, "_waddr"}, 64'(imem_write_addr), 64'd0);
      check({tag, "_wdata"}, 64'(imem_write_data), 64'd0);
      check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
      check({tag, "_done"}, 64'(load_done), 64'd0);
      check({tag, "_err"}, 64'(load_error), 64'd0);
      check({tag, "_wl"}, 64'(words_loaded), 64'd0);
   endtask

   function automatic bq_t rand_image(input int nw);
      bq_t d;
      for (int i = 0; i < 4 * nw; i++) d.push_back(8'($urandom));
      return d;
   endfunction

   initial begin
      bq_t img;
      bq_t empty;
      bq_t r;
      int nw;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_rx_ready", 64'(rx_ready), 64'd0);

      // Normal two-word load (base 0xFFFF, so second write wraps to 0)
      img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_load("normal", 2, img, 8'h00, 1'b0);

      // abort in DONE has no effect
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      check("abort_done_keep", 64'(load_done), 64'd1);
      check("abort_done_noerr", 64'(load_error), 64'd0);

      // Oversize header
      run_load("oversize", 65537, empty, 8'h00, 1'b0);

      // Backpressure with the same image
      run_load("backpressure", 2, img, 8'h00, 1'b1);

      // Random images
      for (int k = 0; k < 6; k++) begin
         nw = $urandom_range(1, 5);
         r  = rand_image(nw);
         run_load("random", 32'(nw), r, 8'h00, 1'($urandom_range(0, 1)));
      end

      // Empty image
      run_load("zero_len", 0, empty, 8'h00, 1'b0);

      // Abort after 1.5 words of a 4-word image
      r = rand_image(4);
      got_addr.delete();
      got_data.delete();
      do_start();
      for (int i = 0; i < 4; i++) send_byte(8'(32'd4 >> (8 * i)), 1'b0);
      for (int i = 0; i < 6; i++) send_byte(r[i], 1'b0);
      @(negedge clk);
      rx_valid = 1'b0;
      abort    = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_done", 64'(load_done), 64'd1);
      check("abort_err", 64'(load_error), 64'd1);
      check("abort_hold", 64'(cpu_hold), 64'd0);
      check("abort_wl", 64'(words_loaded), 64'd1);
      repeat (3) @(negedge clk);
      check_writes("abort", r, 1);

      // Clean load after abort
      r = rand_image(3);
      run_load("after_abort", 3, r, 8'h00, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Bad trailer: error flagged, words still written
      run_load("csum_bad", 2, img, 8'h01, 1'b0);
`endif

      // Asynchronous reset in the middle of a word
      r = rand_image(3);
      got_addr.delete();
      got_data.delete();
      do_start();
      for (int i = 0; i < 4; i++) send_byte(8'(32'd3 >> (8 * i)), 1'b0);
      for (int i = 0; i < 2; i++) send_byte(r[i], 1'b0);
      @(negedge clk);
      rx_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      repeat (4) begin
         @(negedge clk);
         check("postreset_rx_ready", 64'(rx_ready), 64'd0);
      end
      rx_valid = 1'b0;
      check("postreset_nwrites", 64'(got_addr.size()), 64'd0);
      check("postreset_hold", 64'(cpu_hold), 64'd0);

      // Clean load after reset
      r = rand_image(2);
      run_load("after_reset", 2, r, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
